i2s_receiver: RTL and testbench

- Front-end of the audio level meter chain; deserialises an I2S (Philips) stereo stream into 16-bit signed samples.
- Delivers each sample with a channel tag over a valid/ready handshake.
- Its output port set matches the meter's sample input (valid, ready, is_left, 16-bit audio) and connects to it directly on the same clock.
- I2S lines are asynchronous to clk and are oversampled.

---
 rtl/i2s_receiver_pkg.sv | 21 ++
 rtl/i2s_receiver_sync_edge_detector.sv | 29 ++
 rtl/i2s_receiver.sv | 133 +++++++++++++
 tb/tb_i2s_receiver.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_receiver_pkg.sv
// Shared widths, channel encoding and sample payload for the I2S receiver.
package i2s_receiver_pkg;

  localparam int unsigned SAMPLE_WIDTH = 16;
  localparam int unsigned COUNT_WIDTH  = 5;
  localparam logic        WS_LEFT      = 1'b0;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic [COUNT_WIDTH-1:0]  count_t;

  typedef struct packed {
    logic    is_left;
    sample_t audio;
  } sample_beat_t;

  // Left-align a right-justified partial word of `count` bits, zero-filling the LSBs.
  function automatic sample_t left_align(sample_t data, count_t count);
    return data << (COUNT_WIDTH'(SAMPLE_WIDTH) - count);
  endfunction

endpackage

// File: rtl/i2s_receiver_sync_edge_detector.sv
// Multi-flop synchroniser for one asynchronous bit, with its synchronised level
// and a single-cycle rising-edge pulse.
module sync_edge_detector #(
  parameter int unsigned stages = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise_c
);

  logic [stages-1:0] sync_q;
  logic              level_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[stages-2:0], async_in};
      level_d <= sync_q[stages-1];
    end
  end

  assign level  = sync_q[stages-1];
  assign rise_c = level & ~level_d;

endmodule

// File: rtl/i2s_receiver.sv
// I2S (Philips) stereo deserialiser delivering 16-bit samples over valid/ready.
// Define I2S_RECEIVER_LEFT_JUSTIFIED_EN to accept left-justified framing instead.
module i2s_receiver
  import i2s_receiver_pkg::*;
#(
  parameter int unsigned sync_stages = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i2s_sck,
  input  logic                    i2s_ws,
  input  logic                    i2s_sd,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic                    o_is_left,
  output logic [SAMPLE_WIDTH-1:0] o_audio,
  output logic                    o_overrun
);

  logic       sck_rise_c;
  logic       sck_level_unused;
  logic       ws_s;
  logic       sd_s;
  logic [1:0] rise_unused;

  sync_edge_detector #(.stages(sync_stages)) u_sync_sck (
    .clk(clk), .reset(reset), .async_in(i2s_sck), .level(sck_level_unused), .rise_c(sck_rise_c)
  );
  sync_edge_detector #(.stages(sync_stages)) u_sync_ws (
    .clk(clk), .reset(reset), .async_in(i2s_ws), .level(ws_s), .rise_c(rise_unused[0])
  );
  sync_edge_detector #(.stages(sync_stages)) u_sync_sd (
    .clk(clk), .reset(reset), .async_in(i2s_sd), .level(sd_s), .rise_c(rise_unused[1])
  );

  // primed: prev_ws holds a real sampled ws, so a reset release never fakes a boundary
  logic         primed;
  logic         locked;
  logic         prev_ws;
  logic         cur_left;
  sample_t      shift;
  count_t       bit_count;
  logic         emit_pend;
  sample_beat_t emit_beat;

  logic    boundary_c;
  count_t  count_inc_c;
  sample_t shift_inc_c;
  logic    emit_c;
  sample_t emit_audio_c;

  // Next capture state for one shifted-in bit, and the emission decision at a bit event
  always_comb begin
    boundary_c   = primed && (ws_s != prev_ws);
    count_inc_c  = bit_count;
    shift_inc_c  = shift;
    if (bit_count < COUNT_WIDTH'(SAMPLE_WIDTH)) begin
      count_inc_c = bit_count + COUNT_WIDTH'(1);
      shift_inc_c = {shift[SAMPLE_WIDTH-2:0], sd_s};
    end
    emit_c       = 1'b0;
    emit_audio_c = shift_inc_c;
    if (sck_rise_c && locked) begin
      if (!boundary_c) begin
        emit_c = (bit_count == COUNT_WIDTH'(SAMPLE_WIDTH - 1));
      end else begin
`ifdef I2S_RECEIVER_LEFT_JUSTIFIED_EN
        emit_c       = (bit_count != '0) && (bit_count < COUNT_WIDTH'(SAMPLE_WIDTH));
        emit_audio_c = left_align(shift, bit_count);
`else
        // boundary bit closes the previous word; a word already at 16 was emitted earlier
        emit_c       = (bit_count < COUNT_WIDTH'(SAMPLE_WIDTH));
        emit_audio_c = left_align(shift_inc_c, count_inc_c);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      primed    <= 1'b0;
      locked    <= 1'b0;
      prev_ws   <= 1'b0;
      cur_left  <= 1'b0;
      shift     <= '0;
      bit_count <= '0;
      emit_pend <= 1'b0;
      emit_beat <= '0;
      o_valid   <= 1'b0;
      o_is_left <= 1'b0;
      o_audio   <= '0;
      o_overrun <= 1'b0;
    end else begin
      emit_pend <= emit_c;
      if (emit_c) begin
        emit_beat <= '{is_left: cur_left, audio: emit_audio_c};
      end

      if (sck_rise_c) begin
        primed  <= 1'b1;
        prev_ws <= ws_s;
        if (boundary_c) begin
          locked   <= 1'b1;
          cur_left <= (ws_s == WS_LEFT);
`ifdef I2S_RECEIVER_LEFT_JUSTIFIED_EN
          shift     <= SAMPLE_WIDTH'(sd_s);
          bit_count <= COUNT_WIDTH'(1);
`else
          shift     <= '0;
          bit_count <= '0;
`endif
        end else if (locked) begin
          shift     <= shift_inc_c;
          bit_count <= count_inc_c;
        end
      end

      // Output holding register: a sample arriving while one is stalled is dropped
      if (emit_pend) begin
        if (!o_valid || o_ready) begin
          o_valid   <= 1'b1;
          o_is_left <= emit_beat.is_left;
          o_audio   <= emit_beat.audio;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Randomised scoreboard bench for i2s_receiver; follows the build's framing macro.
module tb_i2s_receiver;
  import i2s_receiver_pkg::*;

  localparam int SYNC = 2;
`ifdef I2S_RECEIVER_LEFT_JUSTIFIED_EN
  localparam bit DUT_LJ = 1'b1;
`else
  localparam bit DUT_LJ = 1'b0;
`endif
  localparam bit NATIVE_I2S = !DUT_LJ;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i2s_sck = 1'b0;
  logic        i2s_ws = 1'b0;
  logic        i2s_sd = 1'b0;
  logic        o_valid;
  logic        o_ready = 1'b1;
  logic        o_is_left;
  logic [15:0] o_audio;
  logic        o_overrun;

  i2s_receiver #(.sync_stages(SYNC)) dut (
    .clk(clk), .reset(reset), .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .o_valid(o_valid), .o_ready(o_ready), .o_is_left(o_is_left), .o_audio(o_audio),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_left;
    logic [15:0] audio;
    int          lat_idx;
  } exp_t;

  exp_t        sb[$];
  bit          ws_q[$];
  bit          dat_q[$];
  int          rise_cyc[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          lat_en = 1'b0;
  bit          rand_ready = 1'b0;
  bit          first_seen = 1'b0;
  logic [15:0] first_audio;
  logic        first_left;
  logic        prev_valid = 1'b0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One ws slot: word MSB-first, zero padded to slot_len bits (left-justified data positions)
  function automatic void add_slot(bit ch, logic [31:0] word, int nbits, int slot_len);
    for (int i = 0; i < slot_len; i++) begin
      ws_q.push_back(ch);
      dat_q.push_back(i < nbits ? word[nbits-1-i] : 1'b0);
    end
  endfunction

  // sd seen on the wire at bit k; I2S framing delays data by one bit after ws
  function automatic bit line_sd(int k, bit i2s_fmt);
    if (!i2s_fmt) return dat_q[k];
    return (k > 0) ? dat_q[k-1] : 1'b0;
  endfunction

  // Reference: split the wire stream at ws changes after the first post-reset bit,
  // take each word's first 16 bits left-aligned, per the build's framing rule.
  function automatic void build_expect(bit i2s_fmt, int start);
    int b[$];
    int n;
    n = ws_q.size();
    for (int k = start + 1; k < n; k++)
      if (ws_q[k] != ws_q[k-1]) b.push_back(k);
    for (int j = 0; j < b.size(); j++) begin
      int   first;
      int   last_excl;
      int   len;
      bit   closed;
      exp_t e;
      closed    = (j + 1 < b.size());
      first     = DUT_LJ ? b[j] : b[j] + 1;
      last_excl = closed ? (DUT_LJ ? b[j+1] : b[j+1] + 1) : n;
      len       = last_excl - first;
      if (len <= 0) continue;
      if (!closed && len < 16) continue;
      e.audio = '0;
      for (int i = 0; i < len && i < 16; i++) e.audio[15-i] = line_sd(first + i, i2s_fmt);
      e.is_left = (ws_q[b[j]] == 1'b0);
      e.lat_idx = (len >= 16) ? first + 15 : -1;
      sb.push_back(e);
    end
  endfunction

  // Drive the queued stream, 8 clk per sck period; reset is released before bit rel_idx
  task automatic drive(input bit i2s_fmt, input int rel_idx);
    rise_cyc.delete();
    for (int k = 0; k < ws_q.size(); k++) begin
      @(negedge clk);
      if (k == rel_idx) reset = 1'b1;
      i2s_sck = 1'b0;
      i2s_ws  = ws_q[k];
      i2s_sd  = line_sd(k, i2s_fmt);
      repeat (4) @(negedge clk);
      i2s_sck = 1'b1;
      rise_cyc.push_back(cyc);
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    i2s_sck = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    first_seen = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", o_valid, 0);
    check("reset_is_left", o_is_left, 0);
    check("reset_audio", o_audio, 0);
    check("reset_overrun", o_overrun, 0);
    reset = 1'b1;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 o_ready = r;
  endtask

  task automatic finish_test(input string name);
    repeat (200) @(negedge clk);
    check({name, "_leftover"}, sb.size(), 0);
    ws_q.delete();
    dat_q.delete();
  endtask

  // Monitor: latency on o_valid rise, then scoreboard pop on every transfer
  always @(negedge clk) begin
    if (reset) begin
      if (lat_en && o_valid && !prev_valid && sb.size() > 0 && sb[0].lat_idx >= 0)
        check("latency", cyc - rise_cyc[sb[0].lat_idx], SYNC + 2);
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected: got audio=0x%0h is_left=%0b, expected no sample", o_audio, o_is_left);
        end else begin
          mon_e = sb.pop_front();
          check("audio", o_audio, mon_e.audio);
          check("is_left", o_is_left, mon_e.is_left);
          if (!first_seen) begin
            first_seen  = 1'b1;
            first_audio = o_audio;
            first_left  = o_is_left;
          end
        end
      end
    end
    prev_valid = o_valid;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) o_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    repeat (2) @(negedge clk);

    // 24-bit words in 32-bit slots, latency from the 16th sck edge
    apply_reset();
    lat_en = 1'b1;
    add_slot(1'b1, $urandom, 24, 32);
    for (int f = 0; f < 2; f++) begin
      add_slot(1'b0, 32'h123456, 24, 32);
      add_slot(1'b1, 32'hFEDCBA, 24, 32);
    end
    build_expect(NATIVE_I2S, 0);
    drive(NATIVE_I2S, 0);
    finish_test("frame32");
    lat_en = 1'b0;
    check("frame32_first_audio", first_audio, 16'h1234);
    check("frame32_first_left", first_left, 1);

    // Reset released in the middle of a right slot
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      add_slot(1'b0, $urandom, 24, 32);
      add_slot(1'b1, $urandom, 24, 32);
    end
    reset = 1'b0;
    build_expect(NATIVE_I2S, 40);
    drive(NATIVE_I2S, 40);
    finish_test("midreset");
    check("midreset_first_left", first_left, 1);

    // 8-bit words, zero-filled and emitted at the next ws change
    apply_reset();
    add_slot(1'b1, $urandom, 8, 8);
    add_slot(1'b0, 32'hA5, 8, 8);
    add_slot(1'b1, 32'h3C, 8, 8);
    add_slot(1'b0, $urandom, 8, 8);
    build_expect(NATIVE_I2S, 0);
    drive(NATIVE_I2S, 0);
    finish_test("short8");
    check("short8_first_audio", first_audio, 16'hA500);

    // Back-pressure across two words: first held, second dropped
    apply_reset();
    set_ready(1'b0);
    add_slot(1'b1, $urandom, 16, 32);
    add_slot(1'b0, 32'h1111, 16, 32);
    add_slot(1'b1, 32'h2222, 16, 32);
    build_expect(NATIVE_I2S, 0);
    while (sb.size() > 1) void'(sb.pop_back());
    drive(NATIVE_I2S, 0);
    repeat (20) @(negedge clk);
    check("ovr_valid_held", o_valid, 1);
    check("ovr_audio_held", o_audio, 16'h1111);
    check("ovr_left_held", o_is_left, 1);
    check("ovr_flag", o_overrun, 1);
    set_ready(1'b1);
    finish_test("overrun");
    check("ovr_valid_after", o_valid, 0);
    check("ovr_flag_sticky", o_overrun, 1);

    // Left-justified wire stream; a standard build reads it one bit late
    apply_reset();
    add_slot(1'b1, $urandom, 16, 32);
    add_slot(1'b0, 32'h8001, 16, 32);
    add_slot(1'b1, $urandom, 16, 32);
    build_expect(1'b0, 0);
    drive(1'b0, 0);
    finish_test("ljstream");
    check("lj_first_audio", first_audio, DUT_LJ ? 32'h8001 : 32'h0002);
    check("lj_first_left", first_left, 1);

    // Random words and slot lengths with random o_ready stalls
    apply_reset();
    rand_ready = 1'b1;
    add_slot(1'b1, $urandom, 16, 32);
    for (int s = 0; s < 12; s++) begin
      int sl;
      sl = $urandom_range(8, 32);
      add_slot(s[0], $urandom, $urandom_range(1, sl), sl);
    end
    build_expect(NATIVE_I2S, 0);
    drive(NATIVE_I2S, 0);
    rand_ready = 1'b0;
    set_ready(1'b1);
    finish_test("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
